health_tracker: RTL and testbench



---
 rtl/health_tracker.sv | 101 ++++++++++
 tb/tb_health_tracker.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/health_tracker.sv
// health_tracker: two-player fight FSM with synchronized buttons, per-player attack cooldown,
// health tracking and winner detection; all outputs are registered.
module health_tracker #(
    parameter int MAX_HEALTH = 3,
    parameter int COOLDOWN   = 50000,
    parameter int CD_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       attack1,
    input  logic       attack2,
    input  logic       block1,
    input  logic       block2,
    output logic [1:0] health1,
    output logic [1:0] health2,
    output logic       game_over,
    output logic [1:0] winner
);
    typedef enum logic [1:0] {IDLE, FIGHT, OVER} state_t;

    localparam logic [1:0]      HMAX    = 2'(MAX_HEALTH);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN - 1);
    localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

    state_t          state_q;
    logic [4:0]      s1_q, s2_q;
    logic [2:0]      prev_q;
    logic [CD_W-1:0] cd1_q, cd2_q, cd1_d, cd2_d;
    logic [1:0]      h1_q, h2_q, h1_d, h2_d;
    logic            go_q;
    logic [1:0]      win_q;
    logic [2:0]      pulse;
    logic            fight, acc1, acc2, hit1, hit2;

    // synchronized vector layout: {start, attack1, attack2, block1, block2}
    always_comb begin
        pulse = s2_q[4:2] & ~prev_q;
        fight = state_q == FIGHT;
        acc1  = fight && pulse[1] && cd1_q == '0;
        acc2  = fight && pulse[0] && cd2_q == '0;
        hit1  = acc1 && !s2_q[0];
        hit2  = acc2 && !s2_q[1];
        h2_d  = (hit1 && h2_q != 2'd0) ? h2_q - 2'd1 : h2_q;
        h1_d  = (hit2 && h1_q != 2'd0) ? h1_q - 2'd1 : h1_q;
        cd1_d = !fight ? '0 : acc1 ? CD_LOAD : (cd1_q != '0) ? cd1_q - CD_ONE : '0;
        cd2_d = !fight ? '0 : acc2 ? CD_LOAD : (cd2_q != '0) ? cd2_q - CD_ONE : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
            cd1_q   <= '0;
            cd2_q   <= '0;
            h1_q    <= HMAX;
            h2_q    <= HMAX;
            go_q    <= 1'b0;
            win_q   <= 2'b00;
        end else begin
            s1_q   <= {start, attack1, attack2, block1, block2};
            s2_q   <= s1_q;
            prev_q <= s2_q[4:2];
            cd1_q  <= cd1_d;
            cd2_q  <= cd2_d;
            case (state_q)
                IDLE: begin
                    h1_q <= HMAX;
                    h2_q <= HMAX;
                    if (pulse[2]) state_q <= FIGHT;
                end
                FIGHT: begin
                    h1_q <= h1_d;
                    h2_q <= h2_d;
                    if (h1_d == 2'd0 || h2_d == 2'd0) begin
                        state_q <= OVER;
                        go_q    <= 1'b1;
                        win_q   <= {h1_d == 2'd0, h2_d == 2'd0};
                    end
                end
                OVER: begin
                    if (pulse[2]) begin
                        state_q <= IDLE;
                        h1_q    <= HMAX;
                        h2_q    <= HMAX;
                        go_q    <= 1'b0;
                        win_q   <= 2'b00;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign health1   = h1_q;
    assign health2   = h2_q;
    assign game_over = go_q;
    assign winner    = win_q;
endmodule

// File: tb/tb_health_tracker.sv
// tb_health_tracker: directed vector table, hand-timed corner cases and randomized run against a reference model.
module tb_health_tracker;
    localparam int CD   = 4;
    localparam int MAXH = 3;

    logic       clk, rst_n, start, attack1, attack2, block1, block2;
    logic [1:0] health1, health2, winner;
    logic       game_over;
    int         passed = 0, total = 0;

    health_tracker #(.MAX_HEALTH(MAXH), .COOLDOWN(CD), .CD_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .attack1(attack1), .attack2(attack2),
        .block1(block1), .block2(block2), .health1(health1), .health2(health2),
        .game_over(game_over), .winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: game state in plain integers; cooldown expressed as the edge index of the last accepted attack.
    int         mst, mh1, mh2, n, last1, last2;
    logic       mgo;
    logic [1:0] mwin;
    logic [4:0] hist [3];

    task automatic model_reset();
        mst = 0; mh1 = MAXH; mh2 = MAXH; mgo = 1'b0; mwin = 2'b00; n = 0;
        last1 = -100; last2 = -100;
        for (int i = 0; i < 3; i++) hist[i] = 5'b0;
    endtask

    // Input sampled at edge k affects the state at edge k+2; pulse = rising edge between edges k-3 and k-2.
    task automatic model_step(input logic [4:0] v);
        logic [4:0] e, p;
        logic       sp, a1p, a2p, acc1, acc2;
        e = hist[1]; p = hist[2];
        sp = e[4] & ~p[4]; a1p = e[3] & ~p[3]; a2p = e[2] & ~p[2];
        if (mst == 0) begin
            if (sp) begin mst = 1; last1 = -100; last2 = -100; end
        end else if (mst == 1) begin
            acc1 = a1p && (n - last1 >= CD);
            acc2 = a2p && (n - last2 >= CD);
            if (acc1) last1 = n;
            if (acc2) last2 = n;
            if (acc1 && !e[0] && mh2 > 0) mh2--;
            if (acc2 && !e[1] && mh1 > 0) mh1--;
            if (mh1 == 0 || mh2 == 0) begin
                mst = 2; mgo = 1'b1; mwin = {mh1 == 0, mh2 == 0};
            end
        end else if (sp) begin
            mst = 0; mh1 = MAXH; mh2 = MAXH; mgo = 1'b0; mwin = 2'b00;
        end
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = v; n++;
    endtask

    task automatic step(input logic [4:0] v);
        {start, attack1, attack2, block1, block2} = v;
        @(posedge clk);
        model_step(v);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [1:0] h1e, input logic [1:0] h2e,
                       input logic goe, input logic [1:0] we);
        total++;
        if ({health1, health2, game_over, winner} === {h1e, h2e, goe, we}) passed++;
        else $display("FAIL %s: got h1=%0d h2=%0d go=%b win=%b, expected h1=%0d h2=%0d go=%b win=%b",
                      nm, health1, health2, game_over, winner, h1e, h2e, goe, we);
    endtask

    task automatic do_reset();
        {start, attack1, attack2, block1, block2} = 5'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [4:0] v;
        int         gap;
        logic [1:0] h1, h2;
        logic       go;
        logic [1:0] w;
    } vec_t;

    vec_t tbl [14];

    initial begin
        // {start, attack1, attack2, block1, block2}: pulse for one cycle, then gap idle cycles, then compare
        tbl[0]  = '{5'b00100, 3, 2'd3, 2'd3, 1'b0, 2'b00};
        tbl[1]  = '{5'b10000, 3, 2'd3, 2'd3, 1'b0, 2'b00};
        tbl[2]  = '{5'b01000, 3, 2'd3, 2'd2, 1'b0, 2'b00};
        tbl[3]  = '{5'b00100, 1, 2'd3, 2'd2, 1'b0, 2'b00};
        tbl[4]  = '{5'b00100, 1, 2'd2, 2'd2, 1'b0, 2'b00};
        tbl[5]  = '{5'b00100, 3, 2'd1, 2'd2, 1'b0, 2'b00};
        tbl[6]  = '{5'b01001, 1, 2'd1, 2'd2, 1'b0, 2'b00};
        tbl[7]  = '{5'b01000, 3, 2'd1, 2'd2, 1'b0, 2'b00};
        tbl[8]  = '{5'b01000, 3, 2'd1, 2'd1, 1'b0, 2'b00};
        tbl[9]  = '{5'b01100, 3, 2'd0, 2'd0, 1'b1, 2'b11};
        tbl[10] = '{5'b01000, 3, 2'd0, 2'd0, 1'b1, 2'b11};
        tbl[11] = '{5'b10000, 3, 2'd3, 2'd3, 1'b0, 2'b00};
        tbl[12] = '{5'b10000, 3, 2'd3, 2'd3, 1'b0, 2'b00};
        tbl[13] = '{5'b00100, 3, 2'd2, 2'd3, 1'b0, 2'b00};

        rst_n = 1'b0;
        {start, attack1, attack2, block1, block2} = 5'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_state", 2'd3, 2'd3, 1'b0, 2'b00);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v);
            repeat (tbl[i].gap) step(5'b0);
            chk($sformatf("vec%0d", i), tbl[i].h1, tbl[i].h2, tbl[i].go, tbl[i].w);
        end

        // asynchronous reset mid-fight takes effect before the next clock edge
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 2'd3, 2'd3, 1'b0, 2'b00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(5'b01000);
        repeat (3) step(5'b0);
        chk("idle_after_reset", 2'd3, 2'd3, 1'b0, 2'b00);
        step(5'b10000);
        repeat (3) step(5'b0);

        // hit latency: visible only after the third edge from the rising input
        step(5'b01000);
        chk("lat_edge1", 2'd3, 2'd3, 1'b0, 2'b00);
        step(5'b0);
        chk("lat_edge2", 2'd3, 2'd3, 1'b0, 2'b00);
        step(5'b0);
        chk("lat_edge3", 2'd3, 2'd2, 1'b0, 2'b00);

        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [4:0] v;
            v[4] = $urandom_range(0, 15) == 0;
            v[3] = $urandom_range(0, 2) == 0;
            v[2] = $urandom_range(0, 2) == 0;
            v[1] = $urandom_range(0, 3) == 0;
            v[0] = $urandom_range(0, 3) == 0;
            step(v);
            chk("random", 2'(mh1), 2'(mh2), mgo, mwin);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
